sreg_deser: RTL and testbench

SREG_DESER -- requirements
Module: sreg_deser

---
 rtl/sreg_pkg.sv | 7 +
 rtl/sreg_deser_if.sv | 20 ++
 rtl/sreg_bitcnt.sv | 19 +
 rtl/sreg_deser.sv | 83 ++++++++
 tb/tb_sreg_deser.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sreg_pkg.sv
// sreg_pkg: shared FSM encoding, direction constants and default width for the deserializer.
package sreg_pkg;
  localparam int DEFAULT_N = 8;
  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
endpackage

// File: rtl/sreg_deser_if.sv
// sreg_deser_if: serial input, parallel output handshake and status signals of the deserializer.
interface sreg_deser_if #(parameter int N = 8);
  logic in_bit;
  logic in_valid;
  logic dir;
  logic flush;
  logic [N-1:0] p_out;
  logic out_valid;
  logic out_ready;
  logic overrun;
  logic parity_err;
  modport master (
    output in_bit, in_valid, dir, flush, out_ready,
    input  p_out, out_valid, overrun, parity_err
  );
  modport slave (
    input  in_bit, in_valid, dir, flush, out_ready,
    output p_out, out_valid, overrun, parity_err
  );
endinterface

// File: rtl/sreg_bitcnt.sv
// sreg_bitcnt: received-bit counter with sync clear, increment and terminal count at N-1.
module sreg_bitcnt #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o
);
  localparam int W = $clog2(N + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
  assign tc_o = cnt_q == W'(N - 1);
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sreg_deser.sv
// sreg_deser: serial-to-parallel deserializer with holding register, overrun flag and flush.
// Defining SREG_DESER_PARITY_EN adds a trailing even-parity bit per word (state PAR).
module sreg_deser
  import sreg_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input logic clk,
  input logic clr,
  sreg_deser_if.slave bus
);
  state_t state_q, state_d;
  logic dir_q, dir_d, dir_w, acc, tc, done, load;
  logic [N-1:0] sr_q, sr_d, p_out_q, p_out_d, word;
  logic out_valid_q, out_valid_d, overrun_q, overrun_d;
  assign acc = bus.in_valid && !bus.flush;
  assign dir_w = state_q == IDLE ? bus.dir : dir_q;
  sreg_bitcnt #(.N(N)) u_bitcnt (
    .clk(clk),
    .clr(clr),
    .clear_i(bus.flush || done),
    .inc_i(acc),
    .tc_o(tc)
  );
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    sr_d = sr_q;
    done = 1'b0;
    word = sr_q;
    if (acc && state_q != PAR)
      sr_d = dir_w == DIR_MSB_FIRST ? {sr_q[N-2:0], bus.in_bit} : {bus.in_bit, sr_q[N-1:1]};
    if (acc && state_q == IDLE) dir_d = bus.dir;
    if (bus.flush) state_d = IDLE;
    else if (acc) begin
`ifdef SREG_DESER_PARITY_EN
      done = state_q == PAR;
      state_d = done ? IDLE : (state_q == SHIFT && tc) ? PAR : SHIFT;
`else
      done = state_q == SHIFT && tc;
      word = sr_d;
      state_d = done ? IDLE : SHIFT;
`endif
    end
  end
  // a completing word is taken only if the holding register is free or being emptied now
  assign load = done && (!out_valid_q || bus.out_ready);
  always_comb begin
    p_out_d = load ? word : p_out_q;
    out_valid_d = load || (out_valid_q && !bus.out_ready);
    overrun_d = overrun_q || (done && !load);
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      dir_q <= DIR_LSB_FIRST;
      sr_q <= '0;
      p_out_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      sr_q <= sr_d;
      p_out_q <= p_out_d;
      out_valid_q <= out_valid_d;
      overrun_q <= overrun_d;
    end
  end
`ifdef SREG_DESER_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      perr_q <= 1'b0;
    else if (load) perr_q <= ^{sr_q, bus.in_bit};
  end
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign bus.p_out = p_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_sreg_deser.sv
// tb_sreg_deser: randomized and directed scoreboard bench for sreg_deser against a word-level model.
module tb_sreg_deser;
  import sreg_pkg::*;
  localparam int N = 8;
`ifdef SREG_DESER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clk = 1'b0;
  logic clr = 1'b0;
  sreg_deser_if #(.N(N)) bus();
  sreg_deser #(.N(N)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {logic [N-1:0] w; logic pe;} exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  bit mbits[$];
  logic mdir = 1'b0;
  logic hv = 1'b0;
  logic mov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mbits.delete();
    hv = 1'b0;
    mov = 1'b0;
  endtask

  // one clock: drive inputs, let the edge consume them, then advance the word-level model
  task automatic cyc(input logic ib, input logic iv, input logic d, input logic fl, input logic rdy);
    exp_t e;
    logic done;
    bus.in_bit = ib;
    bus.in_valid = iv;
    bus.dir = d;
    bus.flush = fl;
    bus.out_ready = rdy;
    @(posedge clk);
    done = 1'b0;
    e = '0;
    if (fl) mbits.delete();
    else if (iv) begin
      if (mbits.size() == 0) mdir = d;
      mbits.push_back(ib);
      if (mbits.size() == N + P) begin
        for (int i = 0; i < N; i++) e.w[mdir ? N - 1 - i : i] = mbits[i];
        if (P == 1) foreach (mbits[i]) e.pe ^= mbits[i];
        mbits.delete();
        done = 1'b1;
      end
    end
    if (done && (!hv || rdy)) begin
      sb.push_back(e);
      hv = 1'b1;
    end else if (done) mov = 1'b1;
    else if (rdy) hv = 1'b0;
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic d, input logic rdy, input logic rdy_last);
    logic b;
    for (int i = 0; i < N + P; i++) begin
      b = i < N ? (d ? w[N-1-i] : w[i]) : ^w;
      cyc(b, 1'b1, d, 1'b0, i == N + P - 1 ? rdy_last : rdy);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: got word %0h expected none", bus.p_out);
        end else begin
          e = sb.pop_front();
          chk("sb_word", bus.p_out, e.w);
          chk("sb_perr", bus.parity_err, e.pe);
        end
      end
    end
  end

  initial begin
    bus.in_bit = 0; bus.in_valid = 0; bus.dir = 0; bus.flush = 0; bus.out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_out", bus.p_out, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_perr", bus.parity_err, 0);
    clr = 1'b1;
    cyc(0, 0, 0, 0, 1);
    send_word(8'hA5, DIR_LSB_FIRST, 1, 1);
    chk("lsb_valid", bus.out_valid, 1);
    chk("lsb_word", bus.p_out, 8'hA5);
    cyc(0, 0, 0, 0, 1);
    send_word(8'hA5, DIR_MSB_FIRST, 1, 1);
    chk("msb_a5", bus.p_out, 8'hA5);
    cyc(0, 0, 0, 0, 1);
    send_word(8'hC0, DIR_MSB_FIRST, 1, 1);
    chk("msb_c0", bus.p_out, 8'hC0);
    cyc(0, 0, 0, 0, 1);
    send_word(8'h3C, DIR_LSB_FIRST, 0, 0);
    chk("hold_valid", bus.out_valid, 1);
    send_word(8'hFF, DIR_LSB_FIRST, 0, 0);
    chk("ovr_word", bus.p_out, 8'h3C);
    chk("ovr_flag", bus.overrun, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("ovr_sticky", bus.overrun, 1);
    clr = 1'b0;
    #2;
    model_reset();
    chk("clr_overrun", bus.overrun, 0);
    clr = 1'b1;
    cyc(0, 0, 0, 0, 0);
    send_word(8'h3C, DIR_LSB_FIRST, 0, 0);
    send_word(8'hFF, DIR_LSB_FIRST, 0, 1);
    chk("swap_word", bus.p_out, 8'hFF);
    chk("swap_overrun", bus.overrun, 0);
    chk("swap_valid", bus.out_valid, 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, DIR_LSB_FIRST, 0, 1);
    cyc(1, 1, DIR_LSB_FIRST, 1, 1);
    send_word(8'h96, DIR_LSB_FIRST, 1, 1);
    chk("flush_word", bus.p_out, 8'h96);
    cyc(0, 0, 0, 0, 1);
    send_word(8'h5A, DIR_MSB_FIRST, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, DIR_LSB_FIRST, 0, 0);
    clr = 1'b0;
    #2;
    model_reset();
    chk("mid_p_out", bus.p_out, 0);
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_overrun", bus.overrun, 0);
    chk("mid_perr", bus.parity_err, 0);
    clr = 1'b1;
    send_word(8'h3E, DIR_LSB_FIRST, 1, 1);
    chk("after_clr_word", bus.p_out, 8'h3E);
    cyc(0, 0, 0, 0, 1);
`ifdef SREG_DESER_PARITY_EN
    send_word(8'h01, DIR_LSB_FIRST, 1, 1);
    chk("par_ok_valid", bus.out_valid, 1);
    chk("par_ok", bus.parity_err, 0);
    for (int i = 0; i < 8; i++) cyc(i == 0, 1, DIR_LSB_FIRST, 0, 1);
    chk("par_wait_valid", bus.out_valid, 0);
    cyc(0, 1, DIR_LSB_FIRST, 0, 1);
    chk("par_bad_valid", bus.out_valid, 1);
    chk("par_bad", bus.parity_err, 1);
    cyc(0, 0, 0, 0, 1);
`endif
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
          $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
    repeat (4) cyc(0, 0, 0, 0, 1);
    chk("drain", sb.size(), 0);
    chk("rand_overrun", bus.overrun, mov);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
